// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared combinational ALU.
// A request is registered into a one-deep issue stage, drives the ALU for one
// cycle, and its result is parked in a per-requester response buffer.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration on contention;
// otherwise requester 0 has fixed priority and no pointer register is built.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out
);

  // Don't-care op code presented to the ALU while nothing is issuing.
  localparam logic [3:0] ALU_XXX = 4'hF;

  logic        iss_valid_q, iss_valid_d;
  logic        iss_id_q, iss_id_d;
  logic [31:0] iss_a_q, iss_a_d;
  logic [31:0] iss_b_q, iss_b_d;
  logic [3:0]  iss_op_q, iss_op_d;

  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_data_q, rsp0_data_d;
  logic [31:0] rsp1_data_q, rsp1_data_d;

`ifdef ALU_ARB_RR_EN
  logic        last_q, last_d;
`endif

  logic slot_free0, slot_free1;
  logic eligible0, eligible1;
  logic grant0, grant1;

  // A requester may issue only when it has nothing in the ALU and no parked response.
  always_comb begin
    slot_free0 = !(iss_valid_q && !iss_id_q) && !rsp0_valid_q;
    slot_free1 = !(iss_valid_q && iss_id_q) && !rsp1_valid_q;
    eligible0  = req0_valid && slot_free0;
    eligible1  = req1_valid && slot_free1;
  end

  // Pick at most one winner; nobody is granted while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (eligible0 && eligible1) begin
`ifdef ALU_ARB_RR_EN
        if (last_q) grant0 = 1'b1;
        else        grant1 = 1'b1;
`else
        grant0 = 1'b1;
`endif
      end else begin
        grant0 = eligible0;
        grant1 = eligible1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Load the issue stage from the winner; it empties itself after one cycle.
  always_comb begin
    iss_valid_d = grant0 || grant1;
    iss_id_d    = iss_id_q;
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    iss_op_d    = iss_op_q;
    if (grant1) begin
      iss_id_d = 1'b1;
      iss_a_d  = req1_a;
      iss_b_d  = req1_b;
      iss_op_d = req1_op;
    end else if (grant0) begin
      iss_id_d = 1'b0;
      iss_a_d  = req0_a;
      iss_b_d  = req0_b;
      iss_op_d = req0_op;
    end
  end

  // Drop a response on its handshake, and park the ALU result for the issuing requester.
  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    if (rsp0_valid_q && rsp0_ready) rsp0_valid_d = 1'b0;
    if (rsp1_valid_q && rsp1_ready) rsp1_valid_d = 1'b0;
    if (iss_valid_q && !iss_id_q) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = alu_out;
    end
    if (iss_valid_q && iss_id_q) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = alu_out;
    end
  end

`ifdef ALU_ARB_RR_EN
  // Remember who won last; the pointer only moves when someone is granted.
  always_comb begin
    last_d = last_q;
    if (grant0) last_d = 1'b0;
    if (grant1) last_d = 1'b1;
  end
`endif

  // State registers; reset empties the pipe and discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_q  <= 1'b0;
      iss_id_q     <= 1'b0;
      iss_a_q      <= 32'd0;
      iss_b_q      <= 32'd0;
      iss_op_q     <= ALU_XXX;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= 32'd0;
      rsp1_data_q  <= 32'd0;
`ifdef ALU_ARB_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      iss_valid_q  <= iss_valid_d;
      iss_id_q     <= iss_id_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_op_q     <= iss_op_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
`ifdef ALU_ARB_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  assign alu_a      = iss_valid_q ? iss_a_q  : 32'd0;
  assign alu_b      = iss_valid_q ? iss_b_q  : 32'd0;
  assign alu_op     = iss_valid_q ? iss_op_q : ALU_XXX;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter with a small behavioural ALU.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_SLT = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_XXX = 4'hF;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_op;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_data;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_data;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;

  int checks = 0;
  int errors = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
  );

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    alu_out = 32'd0;
    case (alu_op)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_SLT:  alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      OP_XOR:  alu_out = alu_a ^ alu_b;
      OP_SRA:  alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_out = 32'd0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  logic [5:0] exp_g0, exp_g1, exp_v0, exp_v1;

  initial begin
    rst = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0);
    tick;
    tick;

    $display("[TB] reset state");
    applyStimulus(1, OP_ADD, 5, 7, 1, OP_ADD, 1, 1);
    checkOutput("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    checkOutput("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    checkOutput("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("rst_rsp0_data", rsp0_data, 32'd0);
    checkOutput("rst_rsp1_data", rsp1_data, 32'd0);
    checkOutput("rst_alu_op", {28'd0, alu_op}, {28'd0, OP_XXX});
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0);
    rst = 1'b0;
    tick;

    $display("[TB] idle");
    checkOutput("idle_alu_a", alu_a, 32'd0);
    checkOutput("idle_alu_b", alu_b, 32'd0);
    checkOutput("idle_alu_op", {28'd0, alu_op}, {28'd0, OP_XXX});
    checkOutput("idle_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);

    $display("[TB] single ADD");
    applyStimulus(1, OP_ADD, 5, 7, 0, OP_ADD, 0, 0);
    checkOutput("add_req0_ready_n", {31'd0, req0_ready}, 32'd1);
    tick;
    checkOutput("add_alu_a", alu_a, 32'd5);
    checkOutput("add_alu_b", alu_b, 32'd7);
    checkOutput("add_alu_op", {28'd0, alu_op}, {28'd0, OP_ADD});
    checkOutput("add_rsp0_valid_n1", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("add_req0_ready_n1", {31'd0, req0_ready}, 32'd0);
    tick;
    checkOutput("add_rsp0_valid_n2", {31'd0, rsp0_valid}, 32'd1);
    checkOutput("add_rsp0_data", rsp0_data, 32'd12);
    checkOutput("add_req0_ready_n2", {31'd0, req0_ready}, 32'd0);
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0);
    tick;
    checkOutput("add_rsp0_pulse", {31'd0, rsp0_valid}, 32'd0);

    $display("[TB] contention after a requester-0 grant");
    applyStimulus(1, OP_ADD, 1, 1, 1, OP_ADD, 2, 2);
`ifdef ALU_ARB_RR_EN
    checkOutput("rr_req0_ready", {31'd0, req0_ready}, 32'd0);
    checkOutput("rr_req1_ready", {31'd0, req1_ready}, 32'd1);
`else
    checkOutput("fp_req0_ready", {31'd0, req0_ready}, 32'd1);
    checkOutput("fp_req1_ready", {31'd0, req1_ready}, 32'd0);
`endif
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;

    $display("[TB] contention after reset");
    applyStimulus(1, OP_SUB, 10, 3, 1, OP_SLT, 2, 1);
    checkOutput("con_req0_ready", {31'd0, req0_ready}, 32'd1);
    checkOutput("con_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick;
    checkOutput("con_req1_ready_next", {31'd0, req1_ready}, 32'd1);
    checkOutput("con_alu_op_sub", {28'd0, alu_op}, {28'd0, OP_SUB});
    tick;
    checkOutput("con_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    checkOutput("con_rsp0_data", rsp0_data, 32'd7);
    checkOutput("con_alu_op_slt", {28'd0, alu_op}, {28'd0, OP_SLT});
    checkOutput("con_rsp1_early", {31'd0, rsp1_valid}, 32'd0);
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0);
    tick;
    checkOutput("con_rsp0_clear", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("con_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    checkOutput("con_rsp1_data", rsp1_data, 32'd0);
    tick;
    checkOutput("con_rsp1_clear", {31'd0, rsp1_valid}, 32'd0);

    $display("[TB] both continuously valid");
    exp_g0 = 6'b001001;
    exp_g1 = 6'b010010;
    exp_v0 = 6'b100100;
    exp_v1 = 6'b001000;
    applyStimulus(1, OP_ADD, 1, 2, 1, OP_XOR, 32'h0000_00F0, 32'h0000_000F);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("fair_g0_%0d", k), {31'd0, req0_ready}, {31'd0, exp_g0[k]});
      checkOutput($sformatf("fair_g1_%0d", k), {31'd0, req1_ready}, {31'd0, exp_g1[k]});
      checkOutput($sformatf("fair_v0_%0d", k), {31'd0, rsp0_valid}, {31'd0, exp_v0[k]});
      checkOutput($sformatf("fair_v1_%0d", k), {31'd0, rsp1_valid}, {31'd0, exp_v1[k]});
      if (exp_v0[k]) checkOutput($sformatf("fair_d0_%0d", k), rsp0_data, 32'd3);
      if (exp_v1[k]) checkOutput($sformatf("fair_d1_%0d", k), rsp1_data, 32'h0000_00FF);
      tick;
    end
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0);
    tick;
    tick;
    tick;

    $display("[TB] backpressure on response 0");
    rsp0_ready = 1'b0;
    applyStimulus(1, OP_SRA, 32'h8000_0000, 31, 0, OP_XOR, 0, 0);
    checkOutput("bp_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick;
    applyStimulus(1, OP_SRA, 32'h8000_0000, 31, 1, OP_XOR, 32'h0000_FFFF, 32'h00FF_00FF);
    checkOutput("bp_req0_busy1", {31'd0, req0_ready}, 32'd0);
    checkOutput("bp_req1_ready1", {31'd0, req1_ready}, 32'd1);
    tick;
    checkOutput("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    checkOutput("bp_rsp0_data", rsp0_data, 32'hFFFF_FFFF);
    checkOutput("bp_req1_busy", {31'd0, req1_ready}, 32'd0);
    tick;
    checkOutput("bp_rsp1_valid1", {31'd0, rsp1_valid}, 32'd1);
    checkOutput("bp_rsp1_data1", rsp1_data, 32'h00FF_FF00);
    checkOutput("bp_req0_busy2", {31'd0, req0_ready}, 32'd0);
    applyStimulus(1, OP_SRA, 32'h8000_0000, 31, 1, OP_XOR, 32'h1234_5678, 32'hFFFF_FFFF);
    tick;
    checkOutput("bp_req1_ready2", {31'd0, req1_ready}, 32'd1);
    checkOutput("bp_rsp1_clear", {31'd0, rsp1_valid}, 32'd0);
    checkOutput("bp_rsp0_hold1", rsp0_data, 32'hFFFF_FFFF);
    tick;
    applyStimulus(1, OP_SRA, 32'h8000_0000, 31, 0, OP_XOR, 0, 0);
    tick;
    checkOutput("bp_rsp1_valid2", {31'd0, rsp1_valid}, 32'd1);
    checkOutput("bp_rsp1_data2", rsp1_data, 32'hEDCB_A987);
    checkOutput("bp_rsp0_still", {31'd0, rsp0_valid}, 32'd1);
    checkOutput("bp_rsp0_hold2", rsp0_data, 32'hFFFF_FFFF);
    checkOutput("bp_req0_busy3", {31'd0, req0_ready}, 32'd0);
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0);
    rsp0_ready = 1'b1;
    tick;
    checkOutput("bp_rsp0_released", {31'd0, rsp0_valid}, 32'd0);
    tick;

    $display("[TB] reset mid-operation");
    applyStimulus(1, OP_ADD, 4, 4, 0, OP_ADD, 0, 0);
    checkOutput("mid_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick;
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0);
    rst = 1'b1;
    checkOutput("mid_alu_op_busy", {28'd0, alu_op}, {28'd0, OP_ADD});
    tick;
    rst = 1'b0;
    checkOutput("mid_rsp0_valid1", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("mid_alu_op_xxx", {28'd0, alu_op}, {28'd0, OP_XXX});
    tick;
    checkOutput("mid_rsp0_valid2", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("mid_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    applyStimulus(1, OP_ADD, 1, 1, 1, OP_ADD, 2, 2);
    checkOutput("mid_first_req0", {31'd0, req0_ready}, 32'd1);
    checkOutput("mid_first_req1", {31'd0, req1_ready}, 32'd0);
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0);
    tick;
    checkOutput("end_alu_a", alu_a, 32'd0);
    checkOutput("end_alu_op", {28'd0, alu_op}, {28'd0, OP_XXX});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
